// File: rtl/anim_pkg.sv
// Shared types for the LED-matrix animation sequencer.
// State/mode encodings and a width helper used by the top and the frame ROM.
package anim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    HOLDST
  } anim_state_t;

  typedef enum logic [1:0] {
    M_ONESHOT,
    M_LOOP,
    M_PINGPONG,
    M_RSVD
  } anim_mode_t;

  function automatic int iw_of(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/anim_frame_rom.sv
// Combinational frame store: frame f is a square ring of radius f around the centre.
// Indices at or beyond NFRAMES return a blank bitmap.
module anim_frame_rom
  import anim_pkg::*;
#(
  parameter int ROWS    = 16,
  parameter int COLS    = 16,
  parameter int NFRAMES = 7,
  localparam int IW     = iw_of(NFRAMES)
) (
  input  logic [IW-1:0]                idx,
  output logic [ROWS-1:0][COLS-1:0]    pix
);

  function automatic int absi(int v);
    return (v < 0) ? -v : v;
  endfunction

  // Doubled Chebyshev distance keeps the centre exact for even sizes.
  function automatic int dist2(int r, int c);
    int a;
    int b;
    a = absi(2 * r - (ROWS - 1));
    b = absi(2 * c - (COLS - 1));
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    pix = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (int'(idx) < NFRAMES &&
            dist2(r, c) == 2 * int'(idx) + 1)
          pix[r][c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/anim_sequencer.sv
// Frame-sequence player: one-shot, loop and ping-pong playback
// of ROM frames with a per-frame prescaler, pause and status pulses.
module anim_sequencer
  import anim_pkg::*;
#(
  parameter int ROWS    = 16,
  parameter int COLS    = 16,
  parameter int NFRAMES = 7,
  parameter int FREQDIV = 25,
  localparam int IW     = iw_of(NFRAMES)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic [1:0]                MODE,
  input  logic                      PAUSE,
  output logic [ROWS-1:0][COLS-1:0] PIX,
  output logic [IW-1:0]             FRAME,
  output logic                      BUSY,
  output logic                      HOLD,
  output logic                      DONE,
  output logic                      WRAP
);

  localparam int CW = iw_of(FREQDIV);
  localparam logic [IW-1:0] LAST = IW'(NFRAMES - 1);
  localparam logic [CW-1:0] TOP  = CW'(FREQDIV - 1);

  anim_state_t state_q, state_d;
  anim_mode_t  mode_q, mode_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic          wrap_q, wrap_d;
  logic          tick;

  assign tick = (cnt_q == TOP);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      mode_q  <= M_ONESHOT;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        dir_d = 1'b0;
        cnt_d = '0;
        idx_d = '0;
        if (EN) begin
          state_d = PLAY;
          mode_d  = anim_mode_t'(MODE);
        end
      end
      PLAY: begin
        if (!EN) begin
          state_d = IDLE;
          dir_d   = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (!PAUSE) begin
          if (!tick) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            unique case (mode_q)
              M_LOOP: begin
                if (idx_q == LAST) begin
                  idx_d  = '0;
                  wrap_d = 1'b1;
                end else begin
                  idx_d = idx_q + 1'b1;
                end
              end
              M_PINGPONG: begin
                // A single frame reverses in place, still pulsing WRAP.
                if (!dir_q) begin
                  if (idx_q == LAST) begin
                    dir_d  = 1'b1;
                    idx_d  = (NFRAMES > 1) ? idx_q - 1'b1 : idx_q;
                    wrap_d = 1'b1;
                  end else begin
                    idx_d = idx_q + 1'b1;
                  end
                end else begin
                  if (idx_q == '0) begin
                    dir_d  = 1'b0;
                    idx_d  = (NFRAMES > 1) ? idx_q + 1'b1 : idx_q;
                    wrap_d = 1'b1;
                  end else begin
                    idx_d = idx_q - 1'b1;
                  end
                end
              end
              default: begin
                if (idx_q == LAST) begin
                  state_d = HOLDST;
                  done_d  = 1'b1;
                end else begin
                  idx_d = idx_q + 1'b1;
                end
              end
            endcase
          end
        end
      end
      HOLDST: begin
        if (!EN) begin
          state_d = IDLE;
          dir_d   = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        dir_d   = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  anim_frame_rom #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .NFRAMES (NFRAMES)
  ) u_rom (
    .idx (idx_q),
    .pix (PIX)
  );

  assign FRAME = idx_q;
  assign BUSY  = (state_q == PLAY);
  assign HOLD  = (state_q == HOLDST);
  assign DONE  = done_q;
  assign WRAP  = wrap_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Directed scoreboard bench: a 7-frame/2-cycle player and
// a 1-frame/1-cycle corner instance share the clock and reset.
module tb_anim_sequencer;

  logic CLK = 1'b0;
  logic RST;
  logic EN, PAUSE, EN1, PAUSE1;
  logic [1:0] MODE, MODE1;
  logic [15:0][15:0] PIX, PIX1;
  logic [2:0] FRAME;
  logic [0:0] FRAME1;
  logic BUSY, HOLD, DONE, WRAP;
  logic BUSY1, HOLD1, DONE1, WRAP1;

  int vectors = 0;
  int miscompares = 0;
  int test = 0;

  typedef struct packed {
    logic       sel;
    logic [6:0] st;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  anim_sequencer #(
    .ROWS(16), .COLS(16), .NFRAMES(7), .FREQDIV(2)
  ) u0 (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .PAUSE(PAUSE),
    .PIX(PIX), .FRAME(FRAME), .BUSY(BUSY), .HOLD(HOLD),
    .DONE(DONE), .WRAP(WRAP)
  );

  anim_sequencer #(
    .ROWS(16), .COLS(16), .NFRAMES(1), .FREQDIV(1)
  ) u1 (
    .CLK(CLK), .RST(RST), .EN(EN1), .MODE(MODE1), .PAUSE(PAUSE1),
    .PIX(PIX1), .FRAME(FRAME1), .BUSY(BUSY1), .HOLD(HOLD1),
    .DONE(DONE1), .WRAP(WRAP1)
  );

  function automatic logic [6:0] stv(bit b, bit h, bit d, bit w, int f);
    return {b, h, d, w, 3'(f)};
  endfunction

  // Ring of frame f drawn as the four edges of a square box.
  function automatic logic [15:0][15:0] ring(int f);
    logic [15:0][15:0] p;
    int lo;
    int hi;
    p  = '0;
    lo = 7 - f;
    hi = 8 + f;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (((r == lo || r == hi) && c >= lo && c <= hi) ||
            ((c == lo || c == hi) && r >= lo && r <= hi))
          p[r][c] = 1'b1;
    return p;
  endfunction

  task automatic push(logic sel, logic [6:0] st);
    sb.push_back({sel, st});
  endtask

  task automatic check();
    exp_t e;
    logic [6:0] obs;
    logic [15:0][15:0] pobs;
    e = sb.pop_front();
    obs  = e.sel ? {BUSY1, HOLD1, DONE1, WRAP1, 2'b00, FRAME1}
                 : {BUSY, HOLD, DONE, WRAP, FRAME};
    pobs = e.sel ? PIX1 : PIX;
    vectors++;
    assert (obs === e.st) else begin
      miscompares++;
      $error("FAIL t%0d status{busy,hold,done,wrap,frame} obs=%b exp=%b",
             test, obs, e.st);
    end
    vectors++;
    assert (pobs === ring(int'(e.st[2:0]))) else begin
      miscompares++;
      $error("FAIL t%0d pix frame=%0d obs=%h", test, e.st[2:0], pobs);
    end
  endtask

  task automatic step(logic sel, logic [6:0] st);
    push(sel, st);
    @(posedge CLK);
    #1;
    check();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    RST = 1'b1;
    EN = 1'b0; MODE = 2'd0; PAUSE = 1'b0;
    EN1 = 1'b0; MODE1 = 2'd0; PAUSE1 = 1'b0;
    #1;
    push(1'b0, stv(0, 0, 0, 0, 0));
    check();
    push(1'b1, stv(0, 0, 0, 0, 0));
    check();
    @(negedge CLK);
    RST = 1'b0;

    test = 1;
    EN = 1'b1; MODE = 2'b00;
    for (int k = 0; k < 64; k++)
      step(1'b0, (k < 14) ? stv(1, 0, 0, 0, k / 2)
                          : stv(0, 1, k == 14, 0, 6));
    EN = 1'b0;
    step(1'b0, stv(0, 0, 0, 0, 0));

    test = 2;
    EN = 1'b1; MODE = 2'b01;
    for (int k = 0; k < 42; k++)
      step(1'b0, stv(1, 0, 0, k > 0 && k % 14 == 0, (k / 2) % 7));
    EN = 1'b0;
    step(1'b0, stv(0, 0, 0, 0, 0));

    test = 3;
    EN = 1'b1; MODE = 2'b10;
    for (int k = 0; k < 50; k++) begin
      p = (k / 2) % 12;
      step(1'b0, stv(1, 0, 0,
                     (k % 2 == 0) && (p == 7 || (p == 1 && k >= 24)),
                     (p <= 6) ? p : 12 - p));
    end
    EN = 1'b0;
    step(1'b0, stv(0, 0, 0, 0, 0));

    test = 4;
    EN = 1'b1; MODE = 2'b01;
    for (int k = 0; k < 8; k++)
      step(1'b0, stv(1, 0, 0, 0, k / 2));
    PAUSE = 1'b1;
    MODE = 2'b00;
    for (int k = 0; k < 10; k++)
      step(1'b0, stv(1, 0, 0, 0, 3));
    PAUSE = 1'b0;
    step(1'b0, stv(1, 0, 0, 0, 4));
    step(1'b0, stv(1, 0, 0, 0, 4));
    step(1'b0, stv(1, 0, 0, 0, 5));

    test = 5;
    step(1'b0, stv(1, 0, 0, 0, 5));
    step(1'b0, stv(1, 0, 0, 0, 6));
    step(1'b0, stv(1, 0, 0, 0, 6));
    step(1'b0, stv(1, 0, 0, 1, 0));
    step(1'b0, stv(1, 0, 0, 0, 0));
    for (int k = 2; k < 9; k++)
      step(1'b0, stv(1, 0, 0, 0, k / 2));
    EN = 1'b0;
    step(1'b0, stv(0, 0, 0, 0, 0));
    EN = 1'b1; MODE = 2'b01;
    for (int k = 0; k < 5; k++)
      step(1'b0, stv(1, 0, 0, 0, k / 2));
    #2;
    RST = 1'b1;
    #1;
    push(1'b0, stv(0, 0, 0, 0, 0));
    check();
    @(negedge CLK);
    RST = 1'b0;
    EN = 1'b0;
    step(1'b0, stv(0, 0, 0, 0, 0));

    test = 6;
    EN1 = 1'b1; MODE1 = 2'b00;
    step(1'b1, stv(1, 0, 0, 0, 0));
    step(1'b1, stv(0, 1, 1, 0, 0));
    step(1'b1, stv(0, 1, 0, 0, 0));
    step(1'b1, stv(0, 1, 0, 0, 0));
    EN1 = 1'b0;
    step(1'b1, stv(0, 0, 0, 0, 0));
    EN1 = 1'b1; MODE1 = 2'b01;
    step(1'b1, stv(1, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++)
      step(1'b1, stv(1, 0, 0, 1, 0));
    EN1 = 1'b0;
    step(1'b1, stv(0, 0, 0, 0, 0));
    EN1 = 1'b1; MODE1 = 2'b10;
    step(1'b1, stv(1, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      step(1'b1, stv(1, 0, 0, 1, 0));
    EN1 = 1'b0;
    step(1'b1, stv(0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
